johnson_decoder: RTL
====================

// Module: johnson_decoder
// PURPOSE
//  Receive-side companion to the Johnson (twisted-ring) counter: samples a WIDTH-bit
//  Johnson code word and decodes it to a binary state index. Checks code legality and
//  step legality, tracks lock status and counts errors. Sits downstream of a Johnson
//  counter or a remote Johnson-coded bus, as a decoder and health monitor.
// PARAMETERS
//  WIDTH     4  Johnson word width; 2*WIDTH legal states; IW = $clog2(2*WIDTH)
//  LOCK_CNT  4  consecutive advancing steps needed to declare lock (1..255)
//  ERR_W     8  error counter width
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  en        in   1      sample strobe; din evaluated only on edges with en=1
//  din       in   WIDTH  Johnson code word
//  clr_err   in   1      synchronous clear of err_sticky/err_cnt
//  idx       out  IW     decoded state index 0..2*WIDTH-1
//  code_ok   out  1      last sampled word was a legal Johnson code
//  step_ok   out  1      last sample was a legal code AND a legal transition
//  locked    out  1      lock FSM in LOCKED
//  err_sticky out 1      set on any error, held until clr_err
//  err_cnt   out  ERR_W  saturating error count
// BEHAVIOUR
//  - Reset (reset=0, no clock needed): all outputs 0, have_prev=0, run_cnt=0, FSM=UNLOCKED.
//  - Legal codes: k ones right-justified (k=0..WIDTH), or ones left-justified with
//    (k-WIDTH) zeros at the LSBs (k=WIDTH+1..2*WIDTH-1). W=4: 0000,0001,0011,0111,1111,1110,1100,1000.
//  - Decode: msb=0 -> idx=popcount; msb=1 -> idx=2*WIDTH-popcount.
//  - All outputs registered; latency 1 clk from the sampling edge. en=0: all state holds.
//  - Per en=1 edge: code_ok<=legal(din). Legal: idx<=dec(din). Illegal: idx holds, have_prev<=0.
//  - Step classes (legal din, have_prev=1): HOLD dec==idx; ADV dec==(idx+1) mod 2*WIDTH
//    (7->0 wraps as ADV for W=4); anything else BAD.
//  - have_prev=0 and legal din: fresh acquire, step_ok=1, have_prev<=1, run_cnt unchanged.
//  - step_ok<=1 for HOLD/ADV/fresh; 0 for BAD or illegal code. error = en & ~step_ok(next).
//  - Lock FSM, states UNLOCKED/LOCKED:
//    UNLOCKED: ADV -> run_cnt++ ; run_cnt reaching LOCK_CNT -> LOCKED, run_cnt<=0.
//              HOLD or fresh -> no change; error -> run_cnt<=0.
//    LOCKED:   HOLD/ADV stay; error -> UNLOCKED, run_cnt<=0, locked<=0 same edge.
//  - Error: err_sticky<=1; err_cnt+=1, saturating at 2**ERR_W-1 (no wrap).
//  - clr_err=1: err_sticky<=0, err_cnt<=0; simultaneous error wins: err_sticky<=1, err_cnt<=1.
//    clr_err acts regardless of en; it does not affect lock FSM.
//  - BAD step with legal code: idx updates to new code, have_prev stays 1 (resync).
//  - Reset mid-operation: immediate return to reset values; next legal sample is fresh.
// CONFIGURATION
//  JDEC_REVERSE_EN defined: RET step (dec==(idx-1) mod 2*WIDTH, 0->7 wraps) is legal,
//    counts toward lock like ADV only if same direction as previous non-HOLD step;
//    direction change is legal but run_cnt<=0. Extra port dir out 1: 0=up, 1=down,
//    updated on ADV/RET, reset 0.
//  Not defined: RET is BAD; no dir port.
// TESTING (WIDTH=4, LOCK_CNT=4, ERR_W=8 unless noted)
//  1 reset=0 async, no clk -> all outputs 0 immediately; release, en=1.
//  2 din 0000,0001,0011,0111,1111 on successive edges -> idx 0,1,2,3,4 one clk later,
//    step_ok=1 throughout; locked=1 after edge sampling 1111; err_cnt=0.
//  3 locked, din 1100,1000,0000 -> idx 6,7,0; step_ok=1; locked stays 1 (wrap is ADV).
//  4 locked at idx=2, din=0101 -> code_ok=0, step_ok=0, idx=2, locked=0, err_cnt=1,
//    err_sticky=1; then din=1110 -> fresh, step_ok=1, idx=5, err_cnt=1.
//  5 idx=1, din=0111 (skip) -> step_ok=0, idx=3, err_cnt+1; en=0 with din=0101 -> no change.
//  6 ERR_W=2: five BAD samples -> err_cnt=3 saturated; clr_err with 6th error -> err_cnt=1;
//    clr_err alone -> err_cnt=0, err_sticky=0.
//  7 idx=2, din=0001: JDEC_REVERSE_EN -> step_ok=1, dir=1, idx=1; else step_ok=0, err_cnt+1.

Source files
------------

// File: rtl/johnson_decoder_if.sv
// Sample/status bundle between a Johnson-code source and johnson_decoder.
// The dir signal exists only when JDEC_REVERSE_EN is defined.
interface johnson_decoder_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) ();
   localparam int IW = $clog2(2 * WIDTH);

   logic             en;
   logic [WIDTH-1:0] din;
   logic             clr_err;
   logic [IW-1:0]    idx;
   logic             code_ok;
   logic             step_ok;
   logic             locked;
   logic             err_sticky;
   logic [ERR_W-1:0] err_cnt;
`ifdef JDEC_REVERSE_EN
   logic             dir;

   modport master (
      output en, din, clr_err,
      input  idx, code_ok, step_ok, locked,
      input  err_sticky, err_cnt, dir
   );

   modport slave (
      input  en, din, clr_err,
      output idx, code_ok, step_ok, locked,
      output err_sticky, err_cnt, dir
   );
`else
   modport master (
      output en, din, clr_err,
      input  idx, code_ok, step_ok, locked,
      input  err_sticky, err_cnt
   );

   modport slave (
      input  en, din, clr_err,
      output idx, code_ok, step_ok, locked,
      output err_sticky, err_cnt
   );
`endif
endinterface

// File: rtl/johnson_decoder.sv
// Johnson code decoder and link-health monitor: legality, step, lock, errors.
// Define JDEC_REVERSE_EN to accept backward steps and drive the dir output.
module johnson_decoder #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   johnson_decoder_if.slave bus
);
   localparam int N  = 2 * WIDTH;
   localparam int IW = $clog2(N);

   typedef enum logic {
      UNLOCKED,
      LOCKED
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             code_ok_q, code_ok_d;
   logic             step_ok_q, step_ok_d;
   logic             have_prev_q, have_prev_d;
   logic [7:0]       run_q, run_d;
   logic             sticky_q, sticky_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;

   logic [IW-1:0]    dec;
   logic [IW-1:0]    inc;
   logic             legal;
   logic             err;
   logic             adv;
   logic             ret;
   logic             turn;
   logic             count;
   int               pc;

   // Canonical Johnson word for state i; used to validate the decode.
   function automatic logic [WIDTH-1:0] enc(input logic [IW-1:0] i);
      logic [WIDTH-1:0] c;
      for (int b = 0; b < WIDTH; b++) begin
         if (int'(i) <= WIDTH) c[b] = (b < int'(i));
         else                  c[b] = (b >= int'(i) - WIDTH);
      end
      return c;
   endfunction

   always_comb begin
      pc    = $countones(bus.din);
      dec   = bus.din[WIDTH-1] ? IW'(N - pc) : IW'(pc);
      legal = (enc(dec) == bus.din);
      inc   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
   end

`ifdef JDEC_REVERSE_EN
   logic [IW-1:0] dcr;
   assign dcr = (idx_q == '0) ? IW'(N - 1) : idx_q - 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      code_ok_d   = code_ok_q;
      step_ok_d   = step_ok_q;
      have_prev_d = have_prev_q;
      run_d       = run_q;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      err         = 1'b0;
      adv         = 1'b0;
      ret         = 1'b0;
      turn        = 1'b0;
      count       = 1'b0;

      if (bus.en) begin
         code_ok_d = legal;
         if (!legal) begin
            step_ok_d   = 1'b0;
            have_prev_d = 1'b0;
            err         = 1'b1;
         end else begin
            idx_d       = dec;
            step_ok_d   = 1'b1;
            have_prev_d = 1'b1;
            if (have_prev_q) begin
               unique case (1'b1)
                  (dec == idx_q): ;
                  (dec == inc):   adv = 1'b1;
`ifdef JDEC_REVERSE_EN
                  (dec == dcr):   ret = 1'b1;
`endif
                  default: begin
                     step_ok_d = 1'b0;
                     err       = 1'b1;
                  end
               endcase
            end
         end
      end

      // A reversal is legal but restarts the lock run.
      if (adv || ret) begin
         dir_d = ret;
         turn  = (ret != dir_q);
         count = ~turn;
      end

      if (err) begin
         state_d = UNLOCKED;
         run_d   = '0;
      end else if (turn) begin
         run_d = '0;
      end else if (count && state_q == UNLOCKED) begin
         if (run_q + 8'd1 == 8'(LOCK_CNT)) begin
            state_d = LOCKED;
            run_d   = '0;
         end else begin
            run_d = run_q + 8'd1;
         end
      end

      if (bus.clr_err) begin
         sticky_d = err;
         cnt_d    = ERR_W'(err);
      end else if (err) begin
         sticky_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= UNLOCKED;
         idx_q       <= '0;
         code_ok_q   <= 1'b0;
         step_ok_q   <= 1'b0;
         have_prev_q <= 1'b0;
         run_q       <= '0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         code_ok_q   <= code_ok_d;
         step_ok_q   <= step_ok_d;
         have_prev_q <= have_prev_d;
         run_q       <= run_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
      end
   end

   assign bus.idx        = idx_q;
   assign bus.code_ok    = code_ok_q;
   assign bus.step_ok    = step_ok_q;
   assign bus.locked     = (state_q == LOCKED);
   assign bus.err_sticky = sticky_q;
   assign bus.err_cnt    = cnt_q;
`ifdef JDEC_REVERSE_EN
   assign bus.dir        = dir_q;
`else
   logic unused_dir;
   assign unused_dir = dir_q;
`endif
endmodule
